sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO; next generation of the team's 8x16 FIFO.
- Adds configurable width/depth, occupancy count, almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Used as the standard buffering stage between same-clock producers and consumers in the datapath.

---
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/sync_fifo_param.sv | 103 ++++++++++
 tb/tb_sync_fifo_param.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: producer/consumer side is master,
// the FIFO itself is slave.
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] in;
  logic              rd_en;
  logic [DATA_W-1:0] out;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, in, rd_en,
    input  out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, in, rd_en,
    output out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is registered read.
module sync_fifo_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic              empty_q;
  logic              full_q;
  logic              ae_q;
  logic              af_q;
  logic              ovf_q;
  logic              udf_q;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance looks only at registered flags, never at same-cycle requests.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Storage is never cleared; writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == DEPTH_C);
      ae_q    <= (count_nxt <= AE_C);
      af_q    <= (count_nxt >= AF_C);
      ovf_q   <= bus.wr_en & full_q;
      udf_q   <= bus.rd_en & empty_q;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown combinationally from storage; zero while nothing is stored.
  assign bus.out = empty_q ? '0 : mem[rd_ptr];
`else
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (rd_acc) begin
      out_q <= mem[rd_ptr];
    end
  end

  assign bus.out = out_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed plan plus random traffic
// against a queue-based reference model (follows SYNC_FIFO_FWFT_EN if defined).
module tb_sync_fifo_param;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_out;
  bit                exp_ovf;
  bit                exp_udf;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, check all outputs just after.
  task automatic cycle(input bit r, input bit w, input logic [DATA_W-1:0] d, input bit rd);
    bit was_full, was_empty;
    rst       = r;
    bus.wr_en = w;
    bus.in    = d;
    bus.rd_en = rd;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r) begin
      q.delete();
      exp_out = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      exp_ovf = w & was_full;
      exp_udf = rd & was_empty;
      if (rd && !was_empty) exp_out = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    exp_out = (q.size() != 0) ? q[0] : '0;
`endif
    #1;
    chk("out",          32'(bus.out),          32'(exp_out));
    chk("count",        32'(bus.count),        32'(q.size()));
    chk("empty",        32'(bus.empty),        32'(q.size() == 0));
    chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
    chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
    chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
    chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
    chk("underflow",    32'(bus.underflow),    32'(exp_udf));
  endtask

  initial begin
    exp_out = '0;
    rst = 1'b1; bus.wr_en = 1'b0; bus.in = '0; bus.rd_en = 1'b0;

    // reset state, checked against literal values as well as the model
    cycle(1, 1, 16'h5555, 1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out",   32'(bus.out),   32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);

    // fill 16 words
    for (int i = 1; i <= 16; i++) cycle(0, 1, DATA_W'(i), 0);
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_full",  32'(bus.full),  32'd1);

    // overflow on full
    cycle(0, 1, 16'hBEEF, 0);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    cycle(0, 0, 0, 0);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);

    // drain in order
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_data", 32'(bus.out), 32'(i));
`endif
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // underflow, then simultaneous rd/wr while empty
    cycle(0, 0, 0, 1);
    chk("udf_pulse", 32'(bus.underflow), 32'd1);
    cycle(0, 1, 16'h1234, 1);
    chk("udf_simul_count", 32'(bus.count), 32'd1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // pointer wrap: 4 rounds of write 10 / read 10
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 10; k++) cycle(0, 1, DATA_W'(16'h0100 + r * 10 + k), 0);
      for (int k = 0; k < 10; k++) cycle(0, 0, 0, 1);
      chk("wrap_count", 32'(bus.count), 32'd0);
    end

    // half full, steady simultaneous traffic, then reset mid-stream
    for (int k = 0; k < 8; k++) cycle(0, 1, DATA_W'(16'h0200 + k), 0);
    for (int k = 0; k < 20; k++) cycle(0, 1, DATA_W'(16'h0300 + k), 1);
    chk("steady_count", 32'(bus.count), 32'd8);
    cycle(1, 1, 16'hDEAD, 1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_out",   32'(bus.out),   32'd0);
    cycle(0, 0, 0, 0);

    // single word: fall-through visibility and pop to empty
    cycle(0, 1, 16'h00A5, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head", 32'(bus.out), 32'h00A5);
`endif
    cycle(0, 0, 0, 1);
    chk("single_empty", 32'(bus.empty), 32'd1);

    // random traffic with shifting write/read bias and rare resets
    for (int n = 0; n < 600; n++) begin
      int wp;
      wp = (n / 100) % 2 == 0 ? 70 : 30;
      cycle(($urandom_range(99) == 0),
            ($urandom_range(99) < wp),
            DATA_W'($urandom),
            ($urandom_range(99) < 100 - wp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
